// File: rtl/stream_pack_pkg.sv
// Shared types and slice-index helper for the wide-to-narrow stream unpacker.
package stream_pack_pkg;

    typedef enum logic {MSB_FIRST, LSB_FIRST} slice_order_e;
    typedef enum logic {EMPTY, HOLD} unpack_state_e;

    // Maps the emission count to the slice position inside the wide word.
    function automatic int unsigned slice_idx(input int unsigned cnt,
                                              input int unsigned ratio,
                                              input slice_order_e  order);
        return (order == MSB_FIRST) ? (ratio - 1 - cnt) : cnt;
    endfunction

endpackage

// File: rtl/unpack_slice_sel.sv
// Combinational mux that picks the slice of the held word addressed by the count.
module unpack_slice_sel
    import stream_pack_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter int RATIO = 4,
    parameter int ORDER = 0
) (
    input  logic [OUT_W*RATIO-1:0]     hold,
    input  logic [$clog2(RATIO)-1:0]   cnt,
    output logic [OUT_W-1:0]           o_data
);

    localparam int CW = $clog2(RATIO);
    localparam slice_order_e ORD = (ORDER != 0) ? LSB_FIRST : MSB_FIRST;

    logic [RATIO-1:0][OUT_W-1:0] slices;
    logic [RATIO-1:0][OUT_W-1:0] by_cnt;

    assign slices = hold;

    // Reorder once at elaboration so the runtime mux is indexed by count directly.
    for (genvar g = 0; g < RATIO; g++) begin : g_sel
        localparam int unsigned SI = slice_idx(g, RATIO, ORD);
        assign by_cnt[g] = slices[SI];
    end

    always_comb begin
        o_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (cnt == CW'(i)) o_data = by_cnt[i];
        end
    end

endmodule

// File: rtl/stream_width_unpacker.sv
// Splits each wide input word into RATIO narrow slices with valid/ready on both sides.
module stream_width_unpacker
    import stream_pack_pkg::*;
#(
    parameter int OUT_W = 8,
    parameter int RATIO = 4,
    parameter int ORDER = 0
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic [OUT_W*RATIO-1:0] i_data,
    input  logic                   i_valid,
    input  logic                   i_last,
    output logic                   i_ready,
    output logic [OUT_W-1:0]       o_data,
    output logic                   o_valid,
    output logic                   o_last,
    input  logic                   o_ready
);

    localparam int IN_W = OUT_W * RATIO;
    localparam int CW   = $clog2(RATIO);

    unpack_state_e   state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IN_W-1:0] hold_q, hold_d;
    logic            last_q, last_d;

    logic cnt_last, out_fire, in_fire;

    assign cnt_last = (cnt_q == CW'(RATIO - 1));
    assign o_valid  = (state_q == HOLD);
    assign out_fire = o_valid & o_ready;
    // Ready on the final slice's handshake lets the next word load with no bubble.
    assign i_ready  = (state_q == EMPTY) | (out_fire & cnt_last);
    assign in_fire  = i_valid & i_ready;
    assign o_last   = last_q & cnt_last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        last_d  = last_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = HOLD;
                    hold_d  = i_data;
                    last_d  = i_last;
                    cnt_d   = '0;
                end
            end
            HOLD: begin
                if (out_fire) begin
                    if (!cnt_last) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (in_fire) begin
                        hold_d = i_data;
                        last_d = i_last;
                        cnt_d  = '0;
                    end else begin
                        // Clearing cnt keeps o_last low while idle.
                        state_d = EMPTY;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            hold_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    unpack_slice_sel #(
        .OUT_W (OUT_W),
        .RATIO (RATIO),
        .ORDER (ORDER)
    ) u_sel (
        .hold   (hold_q),
        .cnt    (cnt_q),
        .o_data (o_data)
    );

endmodule

// File: tb/tb_stream_width_unpacker.sv
// Directed and scoreboard checks of the unpacker in MSB-first, LSB-first and RATIO=3 builds.
module tb_stream_width_unpacker;

    logic clock;
    logic rst_n;

    int checks;
    int errors;

    // DUT a: OUT_W=8, RATIO=4, ORDER=0
    logic [31:0] a_i_data;
    logic        a_i_valid, a_i_last, a_i_ready;
    logic [7:0]  a_o_data;
    logic        a_o_valid, a_o_last, a_o_ready;

    // DUT b: OUT_W=8, RATIO=4, ORDER=1
    logic [31:0] b_i_data;
    logic        b_i_valid, b_i_last, b_i_ready;
    logic [7:0]  b_o_data;
    logic        b_o_valid, b_o_last, b_o_ready;

    // DUT c: OUT_W=8, RATIO=3, ORDER=0
    logic [23:0] c_i_data;
    logic        c_i_valid, c_i_last, c_i_ready;
    logic [7:0]  c_o_data;
    logic        c_o_valid, c_o_last, c_o_ready;

    stream_width_unpacker #(.OUT_W(8), .RATIO(4), .ORDER(0)) dut_a (
        .clock(clock), .rst_n(rst_n),
        .i_data(a_i_data), .i_valid(a_i_valid), .i_last(a_i_last), .i_ready(a_i_ready),
        .o_data(a_o_data), .o_valid(a_o_valid), .o_last(a_o_last), .o_ready(a_o_ready)
    );

    stream_width_unpacker #(.OUT_W(8), .RATIO(4), .ORDER(1)) dut_b (
        .clock(clock), .rst_n(rst_n),
        .i_data(b_i_data), .i_valid(b_i_valid), .i_last(b_i_last), .i_ready(b_i_ready),
        .o_data(b_o_data), .o_valid(b_o_valid), .o_last(b_o_last), .o_ready(b_o_ready)
    );

    stream_width_unpacker #(.OUT_W(8), .RATIO(3), .ORDER(0)) dut_c (
        .clock(clock), .rst_n(rst_n),
        .i_data(c_i_data), .i_valid(c_i_valid), .i_last(c_i_last), .i_ready(c_i_ready),
        .o_data(c_o_data), .o_valid(c_o_valid), .o_last(c_o_last), .o_ready(c_o_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick();
        @(negedge clock);
        checks++;
        if (a_o_valid !== 1'b0 || a_o_last !== 1'b0 || a_o_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b last=%b data=%h required 0 0 00",
                     a_o_valid, a_o_last, a_o_data);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clock);
        checks++;
        if (a_i_ready !== 1'b1 || a_o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: i_ready=%b o_valid=%b required 1 0", a_i_ready, a_o_valid);
        end
    endtask

    task automatic test_single_msb;
        logic [7:0] exp [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        tick();
        a_i_data = 32'hA1B2C3D4; a_i_last = 1'b1; a_i_valid = 1'b1; a_o_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (a_i_ready !== 1'b1) begin
            errors++;
            $display("FAIL msb_accept: i_ready=%b required 1", a_i_ready);
        end
        tick();
        a_i_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++;
            if (a_o_valid !== 1'b1 || a_o_data !== exp[k] || a_o_last !== (k == 3) ||
                a_i_ready !== (k == 3)) begin
                errors++;
                $display("FAIL msb_slice%0d: v=%b d=%h l=%b ir=%b required 1 %h %b %b",
                         k, a_o_valid, a_o_data, a_o_last, a_i_ready, exp[k], k == 3, k == 3);
            end
            tick();
        end
        @(negedge clock);
        checks++;
        if (a_o_valid !== 1'b0 || a_o_last !== 1'b0) begin
            errors++;
            $display("FAIL msb_idle: o_valid=%b o_last=%b required 0 0", a_o_valid, a_o_last);
        end
    endtask

    task automatic test_single_lsb;
        logic [7:0] exp [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        tick();
        b_i_data = 32'hA1B2C3D4; b_i_last = 1'b1; b_i_valid = 1'b1; b_o_ready = 1'b1;
        tick();
        b_i_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++;
            if (b_o_valid !== 1'b1 || b_o_data !== exp[k] || b_o_last !== (k == 3)) begin
                errors++;
                $display("FAIL lsb_slice%0d: v=%b d=%h l=%b required 1 %h %b",
                         k, b_o_valid, b_o_data, b_o_last, exp[k], k == 3);
            end
            tick();
        end
        @(negedge clock);
        checks++;
        if (b_o_valid !== 1'b0) begin
            errors++;
            $display("FAIL lsb_idle: o_valid=%b required 0", b_o_valid);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        tick();
        a_i_data = 32'h11223344; a_i_last = 1'b0; a_i_valid = 1'b1; a_o_ready = 1'b1;
        tick();
        a_i_data = 32'h55667788; a_i_last = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            checks++;
            if (a_o_valid !== 1'b1 || a_o_data !== exp[k] || a_o_last !== (k == 7) ||
                a_i_ready !== (k == 3 || k == 7)) begin
                errors++;
                $display("FAIL b2b_slice%0d: v=%b d=%h l=%b ir=%b required 1 %h %b %b",
                         k, a_o_valid, a_o_data, a_o_last, a_i_ready, exp[k], k == 7,
                         (k == 3 || k == 7));
            end
            tick();
            if (k == 3) a_i_valid = 1'b0;
        end
        @(negedge clock);
        checks++;
        if (a_o_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: o_valid=%b required 0", a_o_valid);
        end
    endtask

    task automatic test_backpressure;
        logic       rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [7:0] exp [7] = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h22, 8'h33, 8'h44};
        tick();
        a_i_data = 32'h11223344; a_i_last = 1'b0; a_i_valid = 1'b1; a_o_ready = 1'b1;
        tick();
        a_i_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            a_o_ready = rdy[k];
            @(negedge clock);
            checks++;
            if (a_o_valid !== 1'b1 || a_o_data !== exp[k] || a_o_last !== 1'b0 ||
                a_i_ready !== (k == 6)) begin
                errors++;
                $display("FAIL bp_cycle%0d: v=%b d=%h l=%b ir=%b required 1 %h 0 %b",
                         k, a_o_valid, a_o_data, a_o_last, a_i_ready, exp[k], k == 6);
            end
            tick();
        end
        a_o_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (a_o_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle: o_valid=%b required 0", a_o_valid);
        end
    endtask

    task automatic test_reset_mid_word;
        logic [7:0] exp [4] = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
        tick();
        a_i_data = 32'h11223344; a_i_last = 1'b1; a_i_valid = 1'b1; a_o_ready = 1'b1;
        tick();
        a_i_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_o_valid !== 1'b0 || a_o_data !== 8'h00 || a_o_last !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_assert: v=%b d=%h l=%b required 0 00 0",
                     a_o_valid, a_o_data, a_o_last);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            checks++;
            if (a_o_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_hold%0d: o_valid=%b required 0", k, a_o_valid);
            end
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            checks++;
            if (a_o_valid !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_after%0d: o_valid=%b required 0", k, a_o_valid);
            end
            tick();
        end
        a_i_data = 32'hCAFEBABE; a_i_last = 1'b1; a_i_valid = 1'b1;
        tick();
        a_i_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            checks++;
            if (a_o_valid !== 1'b1 || a_o_data !== exp[k] || a_o_last !== (k == 3)) begin
                errors++;
                $display("FAIL rst_word_slice%0d: v=%b d=%h l=%b required 1 %h %b",
                         k, a_o_valid, a_o_data, a_o_last, exp[k], k == 3);
            end
            tick();
        end
    endtask

    task automatic test_random_ratio3;
        logic [24:0] sb [$];
        int          in_last_cnt  = 0;
        int          out_last_cnt = 0;
        int          words_out    = 0;
        bit          prod_done    = 0;
        tick();
        fork
            begin : producer
                int sent = 0;
                int cyc  = 0;
                c_i_valid = 1'b0;
                while (sent < 200 && cyc < 20000) begin
                    if (!c_i_valid) begin
                        c_i_valid = 1'($urandom_range(0, 1));
                        c_i_data  = 24'($urandom);
                        c_i_last  = 1'($urandom_range(0, 1));
                    end
                    @(negedge clock);
                    if (c_i_valid && c_i_ready) begin
                        sb.push_back({c_i_last, c_i_data});
                        if (c_i_last) in_last_cnt++;
                        sent++;
                        tick();
                        c_i_valid = 1'b0;
                    end else begin
                        tick();
                    end
                    cyc++;
                end
                c_i_valid = 1'b0;
                prod_done = 1;
            end
            begin : consumer
                logic [7:0] s [3];
                int         n   = 0;
                int         cyc = 0;
                while (words_out < 200 && cyc < 20000) begin
                    c_o_ready = 1'($urandom_range(0, 1));
                    @(negedge clock);
                    if (c_o_valid && c_o_ready) begin
                        s[n] = c_o_data;
                        if (c_o_last) out_last_cnt++;
                        if (n < 2 && c_o_last) begin
                            checks++;
                            errors++;
                            $display("FAIL rnd_early_last: o_last=1 on slice %0d required 0", n);
                        end
                        if (n == 2) begin
                            logic [24:0] e;
                            logic [23:0] got;
                            got = {>>{s}};
                            checks++;
                            if (sb.size() == 0) begin
                                errors++;
                                $display("FAIL rnd_word%0d: got %h with empty scoreboard", words_out, got);
                            end else begin
                                e = sb.pop_front();
                                if (got !== e[23:0] || c_o_last !== e[24]) begin
                                    errors++;
                                    $display("FAIL rnd_word%0d: data=%h last=%b required %h %b",
                                             words_out, got, c_o_last, e[23:0], e[24]);
                                end
                            end
                            words_out++;
                            n = 0;
                        end else begin
                            n++;
                        end
                    end
                    tick();
                    cyc++;
                end
                c_o_ready = 1'b0;
            end
        join
        checks++;
        if (words_out !== 200 || !prod_done) begin
            errors++;
            $display("FAIL rnd_timeout: words=%0d producer_done=%0d required 200 1", words_out, prod_done);
        end
        checks++;
        if (out_last_cnt !== in_last_cnt) begin
            errors++;
            $display("FAIL rnd_last_count: out=%0d required %0d", out_last_cnt, in_last_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        a_i_data = '0; a_i_valid = 1'b0; a_i_last = 1'b0; a_o_ready = 1'b0;
        b_i_data = '0; b_i_valid = 1'b0; b_i_last = 1'b0; b_o_ready = 1'b0;
        c_i_data = '0; c_i_valid = 1'b0; c_i_last = 1'b0; c_o_ready = 1'b0;
        test_reset();
        test_single_msb();
        test_single_lsb();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_random_ratio3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
